change_dispenser: RTL and testbench
===================================

# change_dispenser

Change-dispensing state machine that consumes the 5-bit change code produced by the change calculator and issues coins one at a time to the coin mechanism. Code 0 means "waiting", 31 means "transaction complete, no change", and 1–30 is the amount to return. Amounts are split greedily into denominations 20, 10, 5, 2, 1, with a valid/ready handshake per coin. The block sits between the change calculator and the coin-ejector driver.

## Interface
- No parameters; denominations are fixed at 20, 10, 5, 2, 1.
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- moneyToGive  input  5  change code from the calculator: 0 = wait, 1–30 = amount, 31 = no change. Held stable by the source until its next transaction.
- coinReady  input  1  ejector accepts the presented coin this cycle.
- coinValid  output  1  a coin is being presented.
- coinValue  output  5  denomination of the presented coin (20/10/5/2/1); 0 when coinValid=0.
- busy  output  1  high while in DISPENSE.
- done  output  1  one-cycle pulse when the transaction finishes.
- coinsGiven  output  3  number of coins accepted in the current/last transaction.

## Operation
- States: IDLE, DISPENSE, DONE, WAIT_CLEAR. All outputs are registered.
- Greedy function g(r) is the largest denomination ≤ r, giving 20 if r≥20, 10 if r≥10, 5 if r≥5, 2 if r≥2, 1 if r=1.
- IDLE, moneyToGive=0: stay in IDLE; outputs hold at 0, except coinsGiven, which holds its last value.
- IDLE, moneyToGive in 1–30: set remaining=moneyToGive, coinValue=g(moneyToGive), coinValid=1, busy=1, coinsGiven=0; go to DISPENSE.
- IDLE, moneyToGive=31: set coinsGiven=0, done=1; go to DONE. No coin is issued.
- DISPENSE, coinReady=0: hold coinValue, coinValid and remaining unchanged. The handshake is not retracted.
- DISPENSE, coinReady=1: coin accepted. Set remaining=remaining−coinValue and coinsGiven+=1.
  - If the new remaining is 0: coinValid=0, coinValue=0, busy=0, done=1; go to DONE.
  - Otherwise: coinValue=g(new remaining) and coinValid stays 1 with no bubble, so back-to-back coins are possible.
- DONE: done=1 for exactly this one cycle; go to WAIT_CLEAR and drop done to 0.
- WAIT_CLEAR: stay until moneyToGive=0, then go to IDLE. This prevents re-dispensing a held code. Any nonzero value, including a new one, is ignored.
- Changes on moneyToGive during DISPENSE are ignored; the amount is latched at entry.
- remaining is 5-bit unsigned. The greedy choice guarantees coinValue ≤ remaining, so there is no underflow.
- Maximum coin count is 4 (e.g. 29 = 20+5+2+2), so coinsGiven fits in 3 bits with no wrap.

## Timing
- Reset (synchronous): state=IDLE; coinValid, coinValue, busy, done, coinsGiven and remaining all 0. Reset mid-DISPENSE aborts the transaction at that edge; no further coins are issued.
- Latency: a nonzero code sampled at edge N gives coinValid=1 (or done=1 for code 31) after edge N.
- A coin counts as transferred on an edge where coinValid=1 and coinReady=1.
- With coinReady held at 1, an amount needing k coins gives k consecutive coinValid cycles, then done one cycle later.
- coinReady is ignored outside DISPENSE.
- Reset and coinReady on the same edge: reset wins and the coin is not counted.

## Test plan
- **Reset:** assert reset 2 cycles with moneyToGive=0 → all outputs 0, state IDLE; holding moneyToGive=0 keeps outputs 0.
- **Amount 23, coinReady=1:** coinValue sequence 20, 2, 1 on consecutive cycles, then done pulse; coinsGiven=3. Holding 23 afterwards issues no further coins until the input returns to 0.
- **Amount 29 with coinReady toggling 1,0,1,0,...:** each coin (20, 5, 2, 2) is held stable through the not-ready cycles; coinsGiven=4 and done fires once.
- **Code 31:** no coinValid at all; done=1 one cycle after sampling; coinsGiven=0.
- **Abort:** amount 30, accept the 20 coin, then assert reset while the 10 coin is presented → all outputs 0 next cycle. After reset releases with moneyToGive=0 the block stays idle, and a new amount 5 then dispenses a single 5 coin.
- **Input change during DISPENSE:** amount 10 with coinReady=0 for 3 cycles, input changed to 7 meanwhile → a single 10 coin is still dispensed. WAIT_CLEAR then holds until the input is 0.

Source files
------------

// File: rtl/change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : change_dispenser
// Purpose  : Splits a change amount greedily into 20/10/5/2/1 coins and
//            presents them one at a time over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module change_dispenser (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] moneyToGive,
  input  logic       coinReady,
  output logic       coinValid,
  output logic [4:0] coinValue,
  output logic       busy,
  output logic       done,
  output logic [2:0] coinsGiven
);

  localparam logic [4:0] C_NO_CHANGE = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE       = 2'd0,
    ST_DISPENSE   = 2'd1,
    ST_DONE       = 2'd2,
    ST_WAIT_CLEAR = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [4:0] remaining_q, remaining_d;
  logic       coin_valid_q, coin_valid_d;
  logic [4:0] coin_value_q, coin_value_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [2:0] coins_given_q, coins_given_d;
  logic [4:0] w_new_remaining;

  function automatic logic [4:0] greedy(input logic [4:0] r);
    if      (r >= 5'd20) greedy = 5'd20;
    else if (r >= 5'd10) greedy = 5'd10;
    else if (r >= 5'd5)  greedy = 5'd5;
    else if (r >= 5'd2)  greedy = 5'd2;
    else                 greedy = r;
  endfunction

  // Greedy selection keeps coin_value_q <= remaining_q, so this never wraps.
  assign w_new_remaining = remaining_q - coin_value_q;

  always_comb begin
    state_d       = state_q;
    remaining_d   = remaining_q;
    coin_valid_d  = coin_valid_q;
    coin_value_d  = coin_value_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    coins_given_d = coins_given_q;

    case (state_q)
      ST_IDLE: begin
        coin_valid_d = 1'b0;
        coin_value_d = 5'd0;
        busy_d       = 1'b0;
        if (moneyToGive == C_NO_CHANGE) begin
          coins_given_d = 3'd0;
          done_d        = 1'b1;
          state_d       = ST_DONE;
        end else if (moneyToGive != 5'd0) begin
          remaining_d   = moneyToGive;
          coin_value_d  = greedy(moneyToGive);
          coin_valid_d  = 1'b1;
          busy_d        = 1'b1;
          coins_given_d = 3'd0;
          state_d       = ST_DISPENSE;
        end
      end

      ST_DISPENSE: begin
        if (coinReady) begin
          remaining_d   = w_new_remaining;
          coins_given_d = coins_given_q + 3'd1;
          if (w_new_remaining == 5'd0) begin
            coin_valid_d = 1'b0;
            coin_value_d = 5'd0;
            busy_d       = 1'b0;
            done_d       = 1'b1;
            state_d      = ST_DONE;
          end else begin
            coin_value_d = greedy(w_new_remaining);
          end
        end
      end

      ST_DONE: begin
        state_d = ST_WAIT_CLEAR;
      end

      ST_WAIT_CLEAR: begin
        // A held nonzero code must not start a second transaction.
        if (moneyToGive == 5'd0) state_d = ST_IDLE;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      remaining_q   <= 5'd0;
      coin_valid_q  <= 1'b0;
      coin_value_q  <= 5'd0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      coins_given_q <= 3'd0;
    end else begin
      state_q       <= state_d;
      remaining_q   <= remaining_d;
      coin_valid_q  <= coin_valid_d;
      coin_value_q  <= coin_value_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      coins_given_q <= coins_given_d;
    end
  end

  assign coinValid  = coin_valid_q;
  assign coinValue  = coin_value_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign coinsGiven = coins_given_q;

endmodule
`default_nettype wire

// File: tb/tb_change_dispenser.sv
`default_nettype none
// ============================================================================
// Module   : tb_change_dispenser
// Purpose  : Self-checking bench for change_dispenser against a coin-queue
//            reference model, with directed scenarios and random traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_change_dispenser;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] moneyToGive = 5'd0;
  logic       coinReady = 1'b0;
  logic       coinValid;
  logic [4:0] coinValue;
  logic       busy;
  logic       done;
  logic [2:0] coinsGiven;

  int n_checks = 0;
  int n_fail   = 0;

  change_dispenser dut (
    .clock       (clock),
    .reset       (reset),
    .moneyToGive (moneyToGive),
    .coinReady   (coinReady),
    .coinValid   (coinValid),
    .coinValue   (coinValue),
    .busy        (busy),
    .done        (done),
    .coinsGiven  (coinsGiven)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input int actual, input int expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Greedy split expressed as plain arithmetic over the denomination list.
  function automatic void split_amount(input int amount, output int coins[$]);
    int denoms[5] = '{20, 10, 5, 2, 1};
    int r = amount;
    coins.delete();
    while (r > 0) begin
      for (int i = 0; i < 5; i++) begin
        if (denoms[i] <= r) begin
          coins.push_back(denoms[i]);
          r -= denoms[i];
          break;
        end
      end
    end
  endfunction

  // Reference model: a queue of coins still owed, a done pulse, a count,
  // and a flag meaning "a finished code is still being held".
  int m_coins[$];
  bit m_done    = 1'b0;
  bit m_blocked = 1'b0;
  int m_count   = 0;
  bit m_started = 1'b0;

  // Inputs change just after posedge, so at negedge they already hold the
  // values the next rising edge will sample.
  always @(negedge clock) begin
    if (m_started) begin
      check("coinValid",  int'(coinValid),  (m_coins.size() > 0) ? 1 : 0);
      check("coinValue",  int'(coinValue),  (m_coins.size() > 0) ? m_coins[0] : 0);
      check("busy",       int'(busy),       (m_coins.size() > 0) ? 1 : 0);
      check("done",       int'(done),       int'(m_done));
      check("coinsGiven", int'(coinsGiven), m_count);
    end
    if (reset) begin
      m_coins.delete();
      m_done    = 1'b0;
      m_blocked = 1'b0;
      m_count   = 0;
      m_started = 1'b1;
    end else if (m_coins.size() > 0) begin
      if (coinReady) begin
        void'(m_coins.pop_front());
        m_count++;
        if (m_coins.size() == 0) m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done    = 1'b0;
      m_blocked = 1'b1;
    end else if (m_blocked) begin
      if (moneyToGive == 5'd0) m_blocked = 1'b0;
    end else if (moneyToGive == 5'd31) begin
      m_count = 0;
      m_done  = 1'b1;
    end else if (moneyToGive != 5'd0) begin
      split_amount(int'(moneyToGive), m_coins);
      m_count = 0;
    end
  end

  task automatic step(input int n = 1);
    repeat (n) @(posedge clock);
    #1;
  endtask

  initial begin
    int pin[$];
    int done_seen;

    // Pin the model's greedy split with hand-derived values.
    split_amount(29, pin);
    check("model_29_len", pin.size(), 4);
    check("model_29_c0", pin[0], 20);
    check("model_29_c3", pin[3], 2);
    split_amount(23, pin);
    check("model_23_c1", pin[1], 2);

    // Reset
    reset = 1'b1; moneyToGive = 5'd0; coinReady = 1'b0;
    step(2);
    reset = 1'b0;
    step(2);
    check("rst_valid", int'(coinValid), 0);
    check("rst_value", int'(coinValue), 0);
    check("rst_count", int'(coinsGiven), 0);
    check("rst_done",  int'(done), 0);

    // Amount 23, ready held high
    moneyToGive = 5'd23; coinReady = 1'b1;
    step();
    check("a23_c0", int'(coinValue), 20);
    check("a23_busy", int'(busy), 1);
    step();
    check("a23_c1", int'(coinValue), 2);
    step();
    check("a23_c2", int'(coinValue), 1);
    step();
    check("a23_done", int'(done), 1);
    check("a23_valid_end", int'(coinValid), 0);
    check("a23_count", int'(coinsGiven), 3);
    step(3);
    check("a23_hold_valid", int'(coinValid), 0);
    check("a23_hold_done", int'(done), 0);
    moneyToGive = 5'd0;
    step(2);

    // Amount 29, ready toggling
    moneyToGive = 5'd29; coinReady = 1'b0;
    step();
    check("a29_c0", int'(coinValue), 20);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      coinReady = (i % 2 == 0);
      step();
      if (done) done_seen++;
    end
    check("a29_done_once", done_seen, 1);
    check("a29_count", int'(coinsGiven), 4);
    moneyToGive = 5'd0; coinReady = 1'b0;
    step(2);

    // Code 31
    moneyToGive = 5'd31;
    step();
    check("c31_done", int'(done), 1);
    check("c31_valid", int'(coinValid), 0);
    check("c31_count", int'(coinsGiven), 0);
    moneyToGive = 5'd0;
    step(3);

    // Abort by reset mid-dispense
    moneyToGive = 5'd30; coinReady = 1'b1;
    step();
    check("ab_c0", int'(coinValue), 20);
    step();
    check("ab_c1", int'(coinValue), 10);
    reset = 1'b1; moneyToGive = 5'd0;
    step();
    check("ab_valid", int'(coinValid), 0);
    check("ab_value", int'(coinValue), 0);
    check("ab_count", int'(coinsGiven), 0);
    reset = 1'b0;
    step(2);
    check("ab_idle", int'(coinValid), 0);
    moneyToGive = 5'd5;
    step();
    check("ab_five", int'(coinValue), 5);
    step();
    check("ab_five_done", int'(done), 1);
    check("ab_five_count", int'(coinsGiven), 1);
    moneyToGive = 5'd0;
    step(2);

    // Input changes during dispense are ignored
    moneyToGive = 5'd10; coinReady = 1'b0;
    step();
    moneyToGive = 5'd7;
    step(3);
    check("chg_value", int'(coinValue), 10);
    coinReady = 1'b1;
    step();
    check("chg_done", int'(done), 1);
    check("chg_count", int'(coinsGiven), 1);
    step(3);
    check("chg_wait", int'(coinValid), 0);
    moneyToGive = 5'd0;
    step(2);

    // Random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 3) == 0)
        moneyToGive = ($urandom_range(0, 2) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
      coinReady = 1'($urandom);
      reset = ($urandom_range(0, 49) == 0);
      step();
    end
    reset = 1'b0;
    step(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
